monolith_chunk_scheduler: RTL and testbench

//  Sequencer between the chunked stream-sink FIFO and the Monolith permutation core.

---
 rtl/monolith_chunk_scheduler.sv | 144 ++++++++++++++
 tb/tb_monolith_chunk_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/monolith_chunk_scheduler.sv
// Sequencer between the chunk FIFO and the Monolith permutation core.
// Loads one chunk, pulses start, then streams the result as AXI4-Stream beats.
module monolith_chunk_scheduler #(
  parameter int CHUNK_SIZE     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int OUT_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                  S_AXIS_ACLK,
  input  logic                                  S_AXIS_ARESETN,
  input  logic                                  enable,
  input  logic                                  fifo_empty,
  input  logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] fifo_out,
  output logic                                  fifo_read_strobe,
  output logic                                  core_start,
  output logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] core_state,
  input  logic                                  core_done,
  input  logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] core_result,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]                 M_AXIS_TDATA,
  output logic                                  M_AXIS_TLAST,
  output logic                                  busy,
  output logic                                  err_timeout,
  output logic [CNT_WIDTH-1:0]                  chunks_done
);
  localparam int BW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(OUT_WORDS - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, LOAD, RUN, EMIT} state_t;

  state_t                                 state_q, state_d;
  logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0]  core_state_q, core_state_d;
  logic [OUT_WORDS-1:0][DATA_WIDTH-1:0]   result_q, result_d;
  logic [BW-1:0]                          beat_q, beat_d;
  logic [WW-1:0]                          wd_q, wd_d;
  logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
  logic tvalid_q, tvalid_d, strobe_q, strobe_d, start_q, start_d;
  logic busy_q, busy_d, err_q, err_d;

  always_comb begin
    state_d      = state_q;
    core_state_d = core_state_q;
    result_d     = result_q;
    beat_d       = beat_q;
    wd_d         = wd_q;
    cnt_d        = cnt_q;
    tvalid_d     = tvalid_q;
    strobe_d     = 1'b0;
    start_d      = 1'b0;
    err_d        = err_q;
    case (state_q)
      IDLE:   if (enable && !fifo_empty) state_d = SETTLE;
      SETTLE: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          // Latch on entry to LOAD so the core sees the chunk alongside its start pulse.
          state_d      = LOAD;
          core_state_d = fifo_out;
          strobe_d     = 1'b1;
          start_d      = 1'b1;
        end
      end
      LOAD: begin
        state_d = RUN;
        wd_d    = '0;
      end
      RUN: begin
        if (core_done) begin
          for (int i = 0; i < OUT_WORDS; i++) result_d[i] = core_result[i];
          beat_d   = '0;
          tvalid_d = 1'b1;
          state_d  = EMIT;
        end else if (wd_q == WD_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      EMIT: begin
        if (M_AXIS_TREADY) begin
          if (beat_q == LAST_BEAT) begin
            tvalid_d = 1'b0;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q      <= IDLE;
      core_state_q <= '0;
      result_q     <= '0;
      beat_q       <= '0;
      wd_q         <= '0;
      cnt_q        <= '0;
      tvalid_q     <= 1'b0;
      strobe_q     <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_state_q <= core_state_d;
      result_q     <= result_d;
      beat_q       <= beat_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      tvalid_q     <= tvalid_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Only the first OUT_WORDS result words are ever emitted.
  if (OUT_WORDS < CHUNK_SIZE) begin : g_unused
    logic unused_words;
    assign unused_words = ^core_result[CHUNK_SIZE-1:OUT_WORDS];
  end

  assign fifo_read_strobe = strobe_q;
  assign core_start       = start_q;
  assign core_state       = core_state_q;
  assign M_AXIS_TVALID    = tvalid_q;
  assign M_AXIS_TDATA     = result_q[beat_q];
  assign M_AXIS_TLAST     = tvalid_q && (beat_q == LAST_BEAT);
  assign busy             = busy_q;
  assign err_timeout      = err_q;
  assign chunks_done      = cnt_q;
endmodule

// File: tb/tb_monolith_chunk_scheduler.sv
// Scoreboard bench: a core model pushes expected beats when it returns a result,
// an independent monitor pops and compares them on each AXI-Stream handshake.
module tb_monolith_chunk_scheduler;
  localparam int CS = 16, DW = 32, OW = 8, TO = 16, CW = 32;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  logic enable = 1'b0;
  logic fifo_empty;
  logic [CS-1:0][DW-1:0] fifo_out;
  logic fifo_read_strobe, core_start, core_done = 1'b0;
  logic [CS-1:0][DW-1:0] core_state, core_result;
  logic tvalid, tready = 1'b1, tlast, busy, err_timeout;
  logic [DW-1:0] tdata;
  logic [CW-1:0] chunks_done;

  int checks = 0, errors = 0;
  int fifo_cnt = 0, pops = 0, starts = 0, hs_count = 0;
  int core_lat = 10;
  bit tog = 1'b0, saw_valid = 1'b0;
  logic [DW:0] exp_q[$];

  assign fifo_empty = (fifo_cnt == 0);

  always #5 gclk = ~gclk;

  monolith_chunk_scheduler #(.CHUNK_SIZE(CS), .DATA_WIDTH(DW), .OUT_WORDS(OW),
                             .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .S_AXIS_ACLK(gclk), .S_AXIS_ARESETN(grst_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_out(fifo_out), .fifo_read_strobe(fifo_read_strobe),
    .core_start(core_start), .core_state(core_state), .core_done(core_done),
    .core_result(core_result), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast), .busy(busy),
    .err_timeout(err_timeout), .chunks_done(chunks_done));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge gclk); #1;
  endtask

  task automatic wait_start;
    int b = 0;
    do begin @(negedge gclk); b++; end while (!core_start && b < 200);
    chk("start_seen", core_start, 1'b1);
  endtask

  task automatic wait_cnt(input int target);
    int b = 0;
    while (chunks_done != CW'(target) && b < 500) begin @(negedge gclk); b++; end
    chk("chunks_done", chunks_done, target);
  endtask

  // FIFO model: head chunk n holds words (n<<8)|k; a pop exposes the next chunk.
  always_comb for (int k = 0; k < CS; k++) fifo_out[k] = DW'((pops << 8) | k);
  initial forever begin
    @(negedge gclk);
    if (grst_n && fifo_read_strobe) begin
      @(posedge gclk); #1;
      fifo_cnt--;
      pops++;
    end
  end

  // Core model: start number n returns ((n+1)<<8)+k after core_lat cycles.
  initial begin
    core_result = '0;
    forever begin
      @(negedge gclk);
      if (grst_n && core_start) begin
        int n;
        n = starts;
        starts++;
        if (core_lat > 0) begin
          repeat (core_lat) @(posedge gclk);
          #1;
          for (int k = 0; k < CS; k++) core_result[k] = DW'(((n + 1) << 8) + k);
          for (int k = 0; k < OW; k++) exp_q.push_back({(k == OW - 1), DW'(((n + 1) << 8) + k)});
          core_done = 1'b1;
          @(posedge gclk); #1;
          core_done = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge gclk); #1;
    tready = tog ? ~tready : 1'b1;
  end

  // Monitor: handshake is taken at the next posedge, inputs stay stable until then.
  initial begin
    logic held;
    logic [DW:0] held_v, e;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge gclk);
      if (!grst_n || !tvalid) begin
        held = 1'b0;
      end else begin
        saw_valid = 1'b1;
        if (held) chk("stall_hold", {tlast, tdata}, held_v);
        if (tready) begin
          held = 1'b0;
          hs_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {tlast, tdata}, 64'hdead);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {tlast, tdata}, e);
          end
        end else begin
          held = 1'b1;
          held_v = {tlast, tdata};
        end
      end
    end
  end

  initial begin
    int n, base, b, p0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_core_state", core_state, 0);
    chk("rst_cnt", chunks_done, 0);
    chk("rst_err", err_timeout, 0);
    grst_n = 1'b1;
    tick;

    // 1+2: single chunk, load/pop/start timing, 8 beats out
    enable = 1'b1; fifo_cnt = 1;
    tick;
    chk("settle_busy", busy, 1);
    chk("settle_strobe", fifo_read_strobe, 0);
    tick;
    chk("load_strobe", fifo_read_strobe, 1);
    chk("load_start", core_start, 1);
    for (int k = 0; k < CS; k++) chk("load_core_state", core_state[k], k);
    tick;
    chk("run_strobe", fifo_read_strobe, 0);
    chk("run_start", core_start, 0);
    chk("run_core_state_k5", core_state[5], 5);
    wait_cnt(1);
    chk("t2_pops", pops, 1);

    // 3: stalls during EMIT
    tog = 1'b1; fifo_cnt = 1;
    wait_cnt(2);
    tog = 1'b0;
    tick;

    // 4: timeout, then a stray core_done in IDLE is ignored
    saw_valid = 1'b0; core_lat = 0; fifo_cnt = 1;
    wait_start;
    n = 0;
    while (!err_timeout && n < 100) begin @(negedge gclk); n++; end
    chk("timeout_cycles", n, 17);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_busy", busy, 0);
    tick;
    core_done = 1'b1; tick; core_done = 1'b0;
    repeat (3) tick;
    chk("timeout_cnt", chunks_done, 2);
    chk("timeout_busy2", busy, 0);
    chk("timeout_no_tvalid", saw_valid, 0);
    core_lat = 10;

    // 5: enable dropped during RUN of first of two chunks
    p0 = pops; fifo_cnt = 2;
    wait_start;
    repeat (3) tick;
    enable = 1'b0;
    wait_cnt(3);
    repeat (30) tick;
    chk("t5_busy", busy, 0);
    chk("t5_pops", pops, p0 + 1);
    chk("t5_fifo_cnt", fifo_cnt, 1);
    enable = 1'b1;
    wait_cnt(4);
    chk("t5_pops2", pops, p0 + 2);
    tick;

    // 6: reset mid-EMIT after beat 3
    fifo_cnt = 2;
    base = hs_count; b = 0;
    do begin tick; b++; end while (hs_count < base + 4 && b < 300);
    chk("t6_reached_beat3", hs_count >= base + 4, 1);
    grst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_tvalid", tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_core_state", core_state, 0);
    chk("t6_cnt", chunks_done, 0);
    chk("t6_err", err_timeout, 0);
    chk("t6_tdata", tdata, 0);
    tick; tick;
    grst_n = 1'b1;
    wait_cnt(1);
    repeat (3) tick;
    chk("sb_empty", exp_q.size(), 0);
    chk("t6_fifo_cnt", fifo_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
